regfile_ring_arbiter: RTL and testbench

Round-robin writeback arbiter that shares the single ring-update write port of `regfile_TOP` among `NUM_REQ` functional-unit result sources. Each source hands over a (physical register, value) pair with a valid/ready handshake into a one-entry holding slot. The arbiter grants one slot per cycle and drives the registered `ring_update`/`phys_ring`/`phys_ring_val` triple into the register file. A rollback discards all speculative results still pending.

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/regfile_ring_arbiter.sv | 170 +++++++++++++++++
 tb/tb_regfile_ring_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared register-file sizing constants used by regfile_TOP and by the
// writeback ring arbiter, plus small counting helpers used by the optional
// arbiter statistics (RING_ARB_STATS_EN).
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int ARCHFILE_SIZE = 32;
   localparam int PHYSFILE_SIZE = 128;
   localparam int REG_SIZE      = 32;
   localparam int PHYS_W        = $clog2(PHYSFILE_SIZE);

   // Number of set bits in an 8-bit vector (sources are limited to 8).
   function automatic logic [3:0] count_ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   // 32-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[32]) begin
         return 32'hFFFF_FFFF;
      end else begin
         return sum[31:0];
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at index `ptr`
// and proceeds upward with wrap-around; the first set request wins.
// Ports:
//   req       in  N      request vector
//   ptr       in  IW     search start index (0..N-1)
//   grant     out N      one-hot winner (all zero when no request)
//   grant_idx out IW     binary index of the winner (0 when none)
//   any       out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   // Walk offsets 0..N-1 from ptr; the inner compare maps each rotated
   // position back onto a constant slot index so no variable slicing is needed.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (((int'(ptr) + k) % N) == j)) begin
               grant[j]  = 1'b1;
               grant_idx = IW'(j);
               any       = 1'b1;
            end else begin
               any = any;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_ring_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_ring_arbiter
// Shares the single ring-update write port of regfile_TOP among NUM_REQ
// result sources. Each source owns a one-entry holding slot filled through a
// valid/ready handshake; one slot is granted per cycle in round-robin order
// and its (phys, value) pair is driven as a registered write. A rollback
// discards every pending slot.
//
// Optional feature macro: RING_ARB_STATS_EN adds per-source grant counters
// and a rollback drop counter (all saturating).
//
// Ports:
//   clk            in  1                  clock, rising edge
//   rst            in  1                  asynchronous active-high reset
//   req_valid      in  NUM_REQ            source i offers a result
//   req_ready      out NUM_REQ            source i's slot can accept
//   req_phys       in  NUM_REQ*PHYS_W     destination phys reg per source
//   req_val        in  NUM_REQ*REG_SIZE   result value per source
//   rollback       in  1                  flush all pending results
//   ring_update    out 1                  registered write strobe
//   phys_ring      out PHYS_W             registered write index
//   phys_ring_val  out REG_SIZE           registered write value
//   busy           out 1                  any slot pending or write in flight
//   grant_count    out NUM_REQ*32         (RING_ARB_STATS_EN) grants per source
//   drop_count     out 32                 (RING_ARB_STATS_EN) slots dropped
// -----------------------------------------------------------------------------
module regfile_ring_arbiter
   import regfile_pkg::*;
#(
   parameter  int NUM_REQ       = 4,
   parameter  int PHYSFILE_SIZE = regfile_pkg::PHYSFILE_SIZE,
   parameter  int REG_SIZE      = regfile_pkg::REG_SIZE,
   localparam int PHYS_W        = $clog2(PHYSFILE_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*PHYS_W-1:0]    req_phys,
   input  logic [NUM_REQ*REG_SIZE-1:0]  req_val,
   input  logic                         rollback,
   output logic                         ring_update,
   output logic [PHYS_W-1:0]            phys_ring,
   output logic [REG_SIZE-1:0]          phys_ring_val,
   output logic                         busy
`ifdef RING_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]        grant_count,
   output logic [31:0]                  drop_count
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]  hold_valid;
   logic [PHYS_W-1:0]   hold_phys [NUM_REQ];
   logic [REG_SIZE-1:0] hold_val  [NUM_REQ];
   logic [PTR_W-1:0]    rr_ptr;

   logic [NUM_REQ-1:0]  grant_raw;
   logic [NUM_REQ-1:0]  grant;
   logic [NUM_REQ-1:0]  accept;
   logic [PTR_W-1:0]    win_idx;
   logic [PTR_W-1:0]    ptr_next;
   logic                win_any;
   logic                grant_any;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req       (hold_valid),
      .ptr       (rr_ptr),
      .grant     (grant_raw),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   // Rollback suppresses the grant; a granted slot may be refilled in the
   // same cycle, which is why grant feeds req_ready combinationally.
   always_comb begin
      if (rollback) begin
         grant     = '0;
         grant_any = 1'b0;
      end else begin
         grant     = grant_raw;
         grant_any = win_any;
      end
      req_ready = ~{NUM_REQ{rollback}} & (~hold_valid | grant);
      accept    = req_valid & req_ready;
      if (win_idx == PTR_W'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = win_idx + PTR_W'(1);
      end
   end

   // Holding slots: load on accept, clear on grant or rollback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            hold_phys[i] <= '0;
            hold_val[i]  <= '0;
         end
      end else if (rollback) begin
         hold_valid <= '0;
      end else begin
         // A refill in the granted slot wins over the clear.
         hold_valid <= accept | (hold_valid & ~grant);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
               hold_phys[i] <= req_phys[i*PHYS_W +: PHYS_W];
               hold_val[i]  <= req_val[i*REG_SIZE +: REG_SIZE];
            end else begin
               hold_phys[i] <= hold_phys[i];
               hold_val[i]  <= hold_val[i];
            end
         end
      end
   end

   // Registered ring write and round-robin pointer advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring_update   <= 1'b0;
         phys_ring     <= '0;
         phys_ring_val <= '0;
         rr_ptr        <= '0;
      end else if (grant_any) begin
         ring_update   <= 1'b1;
         phys_ring     <= hold_phys[win_idx];
         phys_ring_val <= hold_val[win_idx];
         rr_ptr        <= ptr_next;
      end else begin
         // Index/value hold their last contents; only the strobe drops.
         ring_update <= 1'b0;
      end
   end

   assign busy = (|hold_valid) | ring_update;

`ifdef RING_ARB_STATS_EN
   logic [7:0] hold_valid8;

   // Widen the slot-valid vector to the popcount helper's fixed width.
   always_comb begin
      hold_valid8 = 8'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hold_valid8[i] = hold_valid[i];
      end
   end

   // Saturating grant and drop counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_count <= '0;
         drop_count  <= 32'd0;
      end else if (rollback) begin
         drop_count <= sat_add32(drop_count, {28'd0, count_ones8(hold_valid8)});
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               grant_count[i*32 +: 32] <= sat_add32(grant_count[i*32 +: 32], 32'd1);
            end else begin
               grant_count[i*32 +: 32] <= grant_count[i*32 +: 32];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_ring_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_ring_arbiter
// Self-checking bench for regfile_ring_arbiter: directed scenarios followed by
// randomized traffic, all compared against a slot-level reference model.
// -----------------------------------------------------------------------------
module tb_regfile_ring_arbiter;

   localparam int N  = 4;
   localparam int PW = 7;
   localparam int RW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            rollback;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*PW-1:0] req_phys;
   logic [N*RW-1:0] req_val;
   logic            ring_update;
   logic [PW-1:0]   phys_ring;
   logic [RW-1:0]   phys_ring_val;
   logic            busy;
`ifdef RING_ARB_STATS_EN
   logic [N*32-1:0] grant_count;
   logic [31:0]     drop_count;
`endif

   logic [PW-1:0] src_phys [N];
   logic [RW-1:0] src_val  [N];

   regfile_ring_arbiter #(.NUM_REQ(N), .PHYSFILE_SIZE(128), .REG_SIZE(RW)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_phys      (req_phys),
      .req_val       (req_val),
      .rollback      (rollback),
      .ring_update   (ring_update),
      .phys_ring     (phys_ring),
      .phys_ring_val (phys_ring_val),
      .busy          (busy)
`ifdef RING_ARB_STATS_EN
      ,
      .grant_count   (grant_count),
      .drop_count    (drop_count)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_phys[i*PW +: PW] = src_phys[i];
         req_val[i*RW +: RW]  = src_val[i];
      end
   end

   // Reference model: pending results per source, next-to-serve pointer and
   // the last write presented to the register file.
   bit            m_pend  [N];
   logic [PW-1:0] m_phys  [N];
   logic [RW-1:0] m_val   [N];
   int            m_ptr;
   bit            m_ru;
   logic [PW-1:0] m_pr;
   logic [RW-1:0] m_pv;
   longint        m_gcnt  [N];
   longint        m_drop;

   int vec_count = 0;
   int err_count = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_phys[i] = '0;
         m_val[i]  = '0;
         m_gcnt[i] = 0;
      end
      m_ptr  = 0;
      m_ru   = 1'b0;
      m_pr   = '0;
      m_pv   = '0;
      m_drop = 0;
   endtask

   // Which source the model serves this cycle, or -1.
   function automatic int model_winner();
      if (rollback) return -1;
      for (int k = 0; k < N; k++) begin
         if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // Called at a falling edge with inputs already applied: checks the DUT,
   // advances the model over the next rising edge, returns at the next fall.
   task automatic step();
      int         w;
      logic [N-1:0] exp_ready;
      bit         any_pend;
      int         ndrop;
      #1;
      w = model_winner();
      any_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
         exp_ready[i] = !rollback && (!m_pend[i] || (w == i));
         any_pend = any_pend | m_pend[i];
      end
      check_val("req_ready", 64'(req_ready), 64'(exp_ready));
      check_val("ring_update", 64'(ring_update), 64'(m_ru));
      check_val("phys_ring", 64'(phys_ring), 64'(m_pr));
      check_val("phys_ring_val", 64'(phys_ring_val), 64'(m_pv));
      check_val("busy", 64'(busy), 64'(any_pend | m_ru));
`ifdef RING_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         check_val("grant_count", 64'(grant_count[i*32 +: 32]), 64'(m_gcnt[i]));
      end
      check_val("drop_count", 64'(drop_count), 64'(m_drop));
`endif
      if (rollback) begin
         ndrop = 0;
         for (int i = 0; i < N; i++) begin
            if (m_pend[i]) ndrop++;
            m_pend[i] = 1'b0;
         end
         m_drop = m_drop + ndrop;
         m_ru   = 1'b0;
      end else begin
         if (w >= 0) begin
            m_ru      = 1'b1;
            m_pr      = m_phys[w];
            m_pv      = m_val[w];
            m_pend[w] = 1'b0;
            m_ptr     = (w + 1) % N;
            m_gcnt[w] = m_gcnt[w] + 1;
         end else begin
            m_ru = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && exp_ready[i]) begin
               m_pend[i] = 1'b1;
               m_phys[i] = src_phys[i];
               m_val[i]  = src_val[i];
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Assert reset mid-cycle and check everything clears at once.
   task automatic apply_reset();
      #2;
      rst = 1'b1;
      #1;
      check_val("rst_ring_update", 64'(ring_update), 64'd0);
      check_val("rst_phys_ring", 64'(phys_ring), 64'd0);
      check_val("rst_phys_ring_val", 64'(phys_ring_val), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      req_valid = '0;
      rollback  = 1'b0;
      #0;
      check_val("rst_req_ready", 64'(req_ready), 64'hF);
`ifdef RING_ARB_STATS_EN
      check_val("rst_grant_count", 64'(grant_count != '0), 64'd0);
      check_val("rst_drop_count", 64'(drop_count), 64'd0);
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      rollback  = 1'b0;
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         src_phys[i] = '0;
         src_val[i]  = '0;
      end
      model_reset();
      @(negedge clk);
      apply_reset();

      // Single source 2: visible two edges after the handshake, one cycle only.
      req_valid   = 4'b0100;
      src_phys[2] = 7'h15;
      src_val[2]  = 32'hDEAD_BEEF;
      step();
      req_valid = 4'b0000;
      step();
      check_val("single_ru", 64'(ring_update), 64'd1);
      check_val("single_phys", 64'(phys_ring), 64'h15);
      check_val("single_val", 64'(phys_ring_val), 64'hDEAD_BEEF);
      step();
      check_val("single_ru_drop", 64'(ring_update), 64'd0);
      step();

      // Contention: all four always valid, order 0,1,2,3,0...
      apply_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         src_phys[i] = PW'(i);
         src_val[i]  = 32'h1111_1111 * i;
      end
      step();
      for (int c = 0; c < 8; c++) begin
         step();
         check_val("contend_ru", 64'(ring_update), 64'd1);
         check_val("contend_order", 64'(phys_ring), 64'(c % N));
      end
      req_valid = '0;
      for (int c = 0; c < 6; c++) step();

      // Back-to-back stream from source 1.
      apply_reset();
      for (int n = 0; n < 8; n++) begin
         req_valid   = 4'b0010;
         src_phys[1] = PW'(7'h20 + n);
         src_val[1]  = $urandom;
         #1;
         check_val("b2b_ready", 64'(req_ready[1]), 64'd1);
         step();
         if (n > 0) begin
            check_val("b2b_ru", 64'(ring_update), 64'd1);
            check_val("b2b_phys", 64'(phys_ring), 64'(7'h20 + n - 1));
         end
      end
      req_valid = '0;
      step();
      check_val("b2b_last", 64'(phys_ring), 64'h27);
      step();

      // Rollback discards results held by sources 0 and 3.
      apply_reset();
      req_valid   = 4'b1001;
      src_phys[0] = 7'h01;
      src_phys[3] = 7'h03;
      step();
      req_valid = '0;
      rollback  = 1'b1;
      step();
      rollback = 1'b0;
      check_val("rb_busy", 64'(busy), 64'd0);
`ifdef RING_ARB_STATS_EN
      check_val("rb_drop", 64'(drop_count), 64'd2);
`endif
      for (int c = 0; c < 3; c++) begin
         check_val("rb_no_write", 64'(ring_update), 64'd0);
         step();
      end

      // Rollback together with a valid request: not accepted.
      apply_reset();
      req_valid = 4'b0010;
      rollback  = 1'b1;
      #1;
      check_val("rbv_ready", 64'(req_ready[1]), 64'd0);
      step();
      req_valid = '0;
      rollback  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_val("rbv_no_write", 64'(ring_update), 64'd0);
         check_val("rbv_busy", 64'(busy), 64'd0);
         step();
      end

      // Randomized traffic with occasional rollback and mid-run reset.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            apply_reset();
         end else begin
            req_valid = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15) | $urandom_range(0, 15));
            rollback  = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < N; i++) begin
               src_phys[i] = PW'($urandom_range(0, 127));
               src_val[i]  = $urandom;
            end
            step();
         end
      end

      req_valid = '0;
      rollback  = 1'b0;
      for (int c = 0; c < 6; c++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
